alu_stream: RTL and testbench
=============================

Name: alu_stream

Overview:
- Parametrised successor to the fixed 32-bit ALU. XLEN-wide integer ALU with a valid/ready request/response handshake, configurable execute latency and a result-hold register that supports backpressure.
- Sits between the CU operand registers and the CU writeback/branch logic.
- Carries a tag so the CU can match responses to requests.
- Accepts the same 6-bit CU instruction code as the existing ALU.

Parameters:
- XLEN, 32, operand/result width; legal values 8, 16, 32, 64.
- EXEC_LAT, 2, cycles from accept to out_valid; legal range 1..4.
- TAG_W, 4, width of the request tag passed through unchanged.

Ports:
- soc_clk  in  1  clock; every flop is clocked on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request can be accepted this cycle.
- in_op  in  6  CU instruction code.
- in_dat1  in  XLEN  operand 1 (rs1).
- in_dat2  in  XLEN  operand 2 (rs2 or immediate).
- in_tag  in  TAG_W  request tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  XLEN  result.
- out_overflow  out  1  signed overflow (ADD/SUB only).
- out_con_met  out  1  branch/SLT condition true.
- out_zero  out  1  out_result == 0.
- out_err  out  1  unsupported op code.
- out_tag  out  TAG_W  tag of the request that produced this result.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values:
  - All outputs are 0, except in_ready = 1.
  - State = IDLE, latency counter = 0.
  - Operand, op and tag registers are cleared.
- Op decode:
  - 4 BEQ, 5 BNE, 6 BLT, 7 BGE, 8 BLTU, 9 BGEU.
  - 27/18 ADD, 28 SUB, 29/24 SLL, 30/19 SLT, 31 SLTU, 32/21 XOR, 33/25 SRL, 34/26 SRA, 35/22 OR, 36/23 AND.
  - Any other code: out_err = 1, out_result = 0, out_zero = 1, out_overflow = 0, out_con_met = 0.
- Arithmetic rules:
  - Shift amount = in_dat2[$clog2(XLEN)-1:0]; the upper bits are ignored.
  - ADD/SUB wrap modulo 2^XLEN. overflow = operand signs agree (SUB: after inverting op2) and the result sign differs.
  - SLT/SLTU: out_result = zero-extended con_met.
  - Branches: con_met = condition; out_result = zero-extended con_met.
  - overflow = 0 for every op other than ADD/SUB.
  - con_met = 0 for every op other than branches, SLT and SLTU.
  - zero is always computed from the final out_result.
- State machine (IDLE, EXEC, HOLD):
  - IDLE: in_ready = 1. When in_valid, latch op/operands/tag, load cnt = EXEC_LAT-1, go to EXEC.
  - EXEC: in_ready = 0. When cnt == 0, register all result fields and raise out_valid, go to HOLD; otherwise decrement cnt.
  - HOLD: out_valid = 1, outputs are stable. in_ready = out_ready.
    - out_ready & in_valid: retire the result and accept the new request in the same cycle, go to EXEC. out_valid drops the next cycle.
    - out_ready & !in_valid: go to IDLE, out_valid drops.
    - !out_ready: stay in HOLD; all out_* held unchanged and no new request is accepted.
- Latency: accept on edge N gives out_valid high after edge N+EXEC_LAT. Sustained throughput is one op per EXEC_LAT+1 cycles.
- in_dat*, in_op and in_tag may change freely after accept; the latched copies are used.
- Reset mid-operation (EXEC or HOLD): the pending result is discarded, and reset values are applied on the next edge.
- Simultaneous reset and in_valid: reset wins and the request is not accepted.

Optional Feature:
- Macro ALU_STREAM_MUL_EN.
- Defined:
  - Op code 37 = MUL, low XLEN bits of the product, implemented as an iterative shift-add over XLEN cycles in an extra MUL state.
  - EXEC_LAT is ignored for MUL; MUL latency is XLEN+1 cycles from accept to out_valid.
  - overflow = 1 if the high product half is non-zero (unsigned); con_met = 0.
  - Reset aborts MUL like any other op.
- Undefined: code 37 is an unsupported op and produces out_err = 1. No MUL state or multiplier datapath is built.

Test Plan:
- XLEN=32, EXEC_LAT=2. ADD 0x7FFFFFFF + 1, tag 3 -> out_valid 2 cycles after accept; result 0x80000000, overflow 1, zero 0, tag 3.
- SUB 5 - 5 followed by SRA 0x80000000 by 0x21, with out_ready tied high -> first result 0, zero 1. Second result 0xC0000000, shift amount 1 (upper bits ignored). Second request accepted in the HOLD cycle of the first.
- BLT 0xFFFFFFFF vs 1 -> con_met 1, result 1. BLTU with the same operands -> con_met 0, result 0, zero 1.
- Hold out_ready low for 5 cycles after an XOR 0xF0F0F0F0 ^ 0xFFFFFFFF -> out_result stays 0x0F0F0F0F, out_valid stays high, in_ready stays 0 and a pending in_valid is not accepted. Release out_ready -> the pending request is accepted.
- in_op = 63 -> out_err 1, result 0, zero 1. Assert reset during EXEC of an ADD -> out_valid stays 0, in_ready = 1 on the next cycle.
- ALU_STREAM_MUL_EN defined: MUL 0x10000 * 0x10000 -> result 0, overflow 1, out_valid XLEN+1 cycles after accept. Without the macro, the same request -> out_err 1.

Source files
------------

// File: rtl/alu_stream_if.sv
// Request/response handshake bundle for alu_stream.
// The master drives requests and out_ready; the slave (the ALU) drives results.
interface alu_stream_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [5:0]       in_op;
   logic [XLEN-1:0]  in_dat1;
   logic [XLEN-1:0]  in_dat2;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_result;
   logic             out_overflow;
   logic             out_con_met;
   logic             out_zero;
   logic             out_err;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, in_op, in_dat1, in_dat2, in_tag, out_ready,
      input  in_ready, out_valid, out_result, out_overflow, out_con_met, out_zero, out_err,
             out_tag
   );

   modport slave (
      input  in_valid, in_op, in_dat1, in_dat2, in_tag, out_ready,
      output in_ready, out_valid, out_result, out_overflow, out_con_met, out_zero, out_err,
             out_tag
   );
endinterface

// File: rtl/alu_stream.sv
// XLEN-wide streaming ALU with tag pass-through, configurable latency and a result-hold stage.
// Optional iterative multiplier (op 37) is built only when ALU_STREAM_MUL_EN is defined.
module alu_stream #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned EXEC_LAT = 2,
   parameter int unsigned TAG_W    = 4
) (
   input  logic        soc_clk,
   input  logic        reset,
   alu_stream_if.slave bus,
   output logic        busy
);
   localparam int unsigned ShW = $clog2(XLEN);
   localparam int unsigned Msb = XLEN - 1;

`ifdef ALU_STREAM_MUL_EN
   typedef enum logic [1:0] {StIdle, StExec, StHold, StMul} state_e;
   localparam logic [ShW:0] MulSteps = (ShW + 1)'(XLEN);
   logic [2*XLEN-1:0] acc_q, acc_d, mcand_q, mcand_d;
   logic [ShW:0]      mcnt_q, mcnt_d;
`else
   typedef enum logic [1:0] {StIdle, StExec, StHold} state_e;
`endif

   state_e           state_q, state_d, run_state;
   logic [1:0]       cnt_q, cnt_d;
   logic [5:0]       op_q, op_d;
   logic [XLEN-1:0]  a_q, a_d, b_q, b_d;
   logic [TAG_W-1:0] tag_q, tag_d, otag_q, otag_d;
   logic [XLEN-1:0]  res_q, res_d, res_c, sum, diff;
   logic             ovf_q, ovf_d, ovf_c, con_q, con_d, con_c;
   logic             zero_q, zero_d, zero_c, err_q, err_d, err_c;
   logic             in_ready_c, accept, load_res;
   logic [ShW-1:0]   shamt;

`ifdef ALU_STREAM_MUL_EN
   assign run_state = (bus.in_op == 6'd37) ? StMul : StExec;
`else
   assign run_state = StExec;
`endif

   // State register
   always_ff @(posedge soc_clk) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (bus.in_valid) state_d = run_state;
         StExec: if (cnt_q == 2'd0) state_d = StHold;
         StHold: if (bus.out_ready) state_d = bus.in_valid ? run_state : StIdle;
`ifdef ALU_STREAM_MUL_EN
         StMul:  if (mcnt_q == MulSteps) state_d = StHold;
`endif
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs
   always_comb begin
      in_ready_c = (state_q == StIdle) || ((state_q == StHold) && bus.out_ready);
      accept     = in_ready_c && bus.in_valid;
      load_res   = (state_q == StExec) && (cnt_q == 2'd0);
`ifdef ALU_STREAM_MUL_EN
      load_res   = load_res || ((state_q == StMul) && (mcnt_q == MulSteps));
`endif
      busy       = (state_q != StIdle);
   end

   // Result computation from the latched request
   always_comb begin
      res_c = '0;
      ovf_c = 1'b0;
      con_c = 1'b0;
      err_c = 1'b0;
      sum   = a_q + b_q;
      diff  = a_q - b_q;
      shamt = b_q[ShW-1:0];
      case (op_q)
         6'd4:         con_c = (a_q == b_q);
         6'd5:         con_c = (a_q != b_q);
         6'd6:         con_c = ($signed(a_q) < $signed(b_q));
         6'd7:         con_c = ($signed(a_q) >= $signed(b_q));
         6'd8:         con_c = (a_q < b_q);
         6'd9:         con_c = (a_q >= b_q);
         6'd27, 6'd18: begin
            res_c = sum;
            ovf_c = (a_q[Msb] == b_q[Msb]) && (sum[Msb] != a_q[Msb]);
         end
         6'd28: begin
            res_c = diff;
            ovf_c = (a_q[Msb] != b_q[Msb]) && (diff[Msb] != a_q[Msb]);
         end
         6'd29, 6'd24: res_c = a_q << shamt;
         6'd30, 6'd19: con_c = ($signed(a_q) < $signed(b_q));
         6'd31:        con_c = (a_q < b_q);
         6'd32, 6'd21: res_c = a_q ^ b_q;
         6'd33, 6'd25: res_c = a_q >> shamt;
         6'd34, 6'd26: res_c = $unsigned($signed(a_q) >>> shamt);
         6'd35, 6'd22: res_c = a_q | b_q;
         6'd36, 6'd23: res_c = a_q & b_q;
`ifdef ALU_STREAM_MUL_EN
         6'd37: begin
            res_c = acc_q[XLEN-1:0];
            ovf_c = |acc_q[2*XLEN-1:XLEN];
         end
`endif
         default:      err_c = 1'b1;
      endcase
      // Only branch/SLT ops ever set con_c, and their result is the condition itself
      if (con_c) res_c = XLEN'(1'b1);
      zero_c = (res_c == '0);
   end

   // Operand, counter and result-hold next state
   always_comb begin
      op_d   = op_q;
      a_d    = a_q;
      b_d    = b_q;
      tag_d  = tag_q;
      cnt_d  = cnt_q;
      res_d  = res_q;
      ovf_d  = ovf_q;
      con_d  = con_q;
      zero_d = zero_q;
      err_d  = err_q;
      otag_d = otag_q;
`ifdef ALU_STREAM_MUL_EN
      acc_d   = acc_q;
      mcand_d = mcand_q;
      mcnt_d  = mcnt_q;
`endif
      if (accept) begin
         op_d  = bus.in_op;
         a_d   = bus.in_dat1;
         b_d   = bus.in_dat2;
         tag_d = bus.in_tag;
         cnt_d = 2'(EXEC_LAT - 1);
`ifdef ALU_STREAM_MUL_EN
         acc_d   = '0;
         mcand_d = {{XLEN{1'b0}}, bus.in_dat1};
         mcnt_d  = '0;
`endif
      end else if ((state_q == StExec) && (cnt_q != 2'd0)) begin
         cnt_d = cnt_q - 2'd1;
`ifdef ALU_STREAM_MUL_EN
      end else if ((state_q == StMul) && (mcnt_q != MulSteps)) begin
         // Shift-add: multiplier consumed LSB-first out of b_q
         if (b_q[0]) acc_d = acc_q + mcand_q;
         mcand_d = mcand_q << 1;
         b_d     = b_q >> 1;
         mcnt_d  = mcnt_q + 1'b1;
`endif
      end
      if (load_res) begin
         res_d  = res_c;
         ovf_d  = ovf_c;
         con_d  = con_c;
         zero_d = zero_c;
         err_d  = err_c;
         otag_d = tag_q;
      end
   end

   always_ff @(posedge soc_clk) begin
      if (reset) begin
         cnt_q  <= '0;
         op_q   <= '0;
         a_q    <= '0;
         b_q    <= '0;
         tag_q  <= '0;
         res_q  <= '0;
         ovf_q  <= 1'b0;
         con_q  <= 1'b0;
         zero_q <= 1'b0;
         err_q  <= 1'b0;
         otag_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         op_q   <= op_d;
         a_q    <= a_d;
         b_q    <= b_d;
         tag_q  <= tag_d;
         res_q  <= res_d;
         ovf_q  <= ovf_d;
         con_q  <= con_d;
         zero_q <= zero_d;
         err_q  <= err_d;
         otag_q <= otag_d;
      end
   end

`ifdef ALU_STREAM_MUL_EN
   always_ff @(posedge soc_clk) begin
      if (reset) begin
         acc_q   <= '0;
         mcand_q <= '0;
         mcnt_q  <= '0;
      end else begin
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         mcnt_q  <= mcnt_d;
      end
   end
`endif

   assign bus.in_ready     = in_ready_c;
   assign bus.out_valid    = (state_q == StHold);
   assign bus.out_result   = res_q;
   assign bus.out_overflow = ovf_q;
   assign bus.out_con_met  = con_q;
   assign bus.out_zero     = zero_q;
   assign bus.out_err      = err_q;
   assign bus.out_tag      = otag_q;
endmodule

// File: tb/tb_alu_stream.sv
// Directed-vector bench for alu_stream (XLEN=32, EXEC_LAT=2).
// Expected values are hand-computed; MUL expectations follow ALU_STREAM_MUL_EN.
module tb_alu_stream;
   localparam int unsigned XLEN     = 32;
   localparam int unsigned EXEC_LAT = 2;
   localparam int unsigned TAG_W    = 4;

   logic soc_clk = 1'b0;
   logic reset;
   logic busy;
   int   checks   = 0;
   int   failures = 0;

   alu_stream_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

   alu_stream #(
      .XLEN     (XLEN),
      .EXEC_LAT (EXEC_LAT),
      .TAG_W    (TAG_W)
   ) u_dut (
      .soc_clk (soc_clk),
      .reset   (reset),
      .bus     (bus),
      .busy    (busy)
   );

   always #5 soc_clk = ~soc_clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge soc_clk);
      #1;
   endtask

   // Present a request and hold it until the edge that accepts it
   task automatic issue(input logic [5:0] op, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [3:0] tag);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_op    = op;
      bus.in_dat1  = d1;
      bus.in_dat2  = d2;
      bus.in_tag   = tag;
      while (!bus.in_ready && n < 200) begin
         step();
         n++;
      end
      check_eq("accept_ready", 64'(bus.in_ready), 64'd1);
      step();
      bus.in_valid = 1'b0;
      bus.in_op    = 6'd0;
      bus.in_dat1  = '1;
      bus.in_dat2  = '1;
      bus.in_tag   = '1;
   endtask

   task automatic await_valid(input string tag, input int exp_lat);
      int n = 0;
      while (!bus.out_valid && n < 200) begin
         step();
         n++;
      end
      check_eq({tag, "_lat"}, 64'(n), 64'(exp_lat));
   endtask

   task automatic check_res(input string tag, input logic [31:0] res, input logic ovf,
                            input logic con, input logic zero, input logic err,
                            input logic [3:0] t);
      check_eq({tag, "_res"},  64'(bus.out_result),   64'(res));
      check_eq({tag, "_ovf"},  64'(bus.out_overflow), 64'(ovf));
      check_eq({tag, "_con"},  64'(bus.out_con_met),  64'(con));
      check_eq({tag, "_zero"}, 64'(bus.out_zero),     64'(zero));
      check_eq({tag, "_err"},  64'(bus.out_err),      64'(err));
      check_eq({tag, "_tag"},  64'(bus.out_tag),      64'(t));
   endtask

   initial begin
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_op     = '0;
      bus.in_dat1   = '0;
      bus.in_dat2   = '0;
      bus.in_tag    = '0;
      bus.out_ready = 1'b1;
      step();
      step();
      reset = 1'b0;

      check_eq("rst_in_ready",  64'(bus.in_ready),  64'd1);
      check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check_eq("rst_busy",      64'(busy),          64'd0);
      check_res("rst", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

      // ADD overflow
      issue(6'd27, 32'h7FFF_FFFF, 32'h1, 4'd3);
      check_eq("add_busy", 64'(busy), 64'd1);
      await_valid("add", EXEC_LAT);
      check_res("add", 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3);
      step();
      check_eq("add_retire", 64'(bus.out_valid), 64'd0);

      // SUB to zero, then SRA accepted in the HOLD cycle
      issue(6'd28, 32'd5, 32'd5, 4'd1);
      await_valid("sub", EXEC_LAT);
      check_res("sub", 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1);
      check_eq("sub_hold_ready", 64'(bus.in_ready), 64'd1);
      issue(6'd34, 32'h8000_0000, 32'h21, 4'd2);
      check_eq("sra_valid_drop", 64'(bus.out_valid), 64'd0);
      await_valid("sra", EXEC_LAT);
      check_res("sra", 32'hC000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);

      // Signed vs unsigned less-than
      issue(6'd6, 32'hFFFF_FFFF, 32'h1, 4'd4);
      await_valid("blt", EXEC_LAT);
      check_res("blt", 32'h1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4);
      issue(6'd8, 32'hFFFF_FFFF, 32'h1, 4'd5);
      await_valid("bltu", EXEC_LAT);
      check_res("bltu", 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5);

      // Backpressure: XOR result held while a new request waits
      issue(6'd32, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 4'd10);
      bus.out_ready = 1'b0;
      await_valid("xor", EXEC_LAT);
      bus.in_valid = 1'b1;
      bus.in_op    = 6'd18;
      bus.in_dat1  = 32'd2;
      bus.in_dat2  = 32'd3;
      bus.in_tag   = 4'd9;
      for (int i = 0; i < 5; i++) begin
         step();
         check_eq("bp_res",      64'(bus.out_result), 64'h0F0F_0F0F);
         check_eq("bp_valid",    64'(bus.out_valid),  64'd1);
         check_eq("bp_in_ready", 64'(bus.in_ready),   64'd0);
         check_eq("bp_tag",      64'(bus.out_tag),    64'd10);
      end
      bus.out_ready = 1'b1;
      #1;
      check_eq("bp_release_ready", 64'(bus.in_ready), 64'd1);
      step();
      bus.in_valid = 1'b0;
      bus.in_dat1  = '0;
      check_eq("bp_valid_drop", 64'(bus.out_valid), 64'd0);
      check_eq("bp_busy",       64'(busy),          64'd1);
      await_valid("add18", EXEC_LAT);
      check_res("add18", 32'd5, 1'b0, 1'b0, 1'b0, 1'b0, 4'd9);

      // Unsupported op
      issue(6'd63, 32'd1, 32'd2, 4'd6);
      await_valid("bad", EXEC_LAT);
      check_res("bad", 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd6);

      // Reset during EXEC discards the request
      issue(6'd27, 32'd1, 32'd1, 4'd7);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_eq("rexec_valid", 64'(bus.out_valid),  64'd0);
      check_eq("rexec_ready", 64'(bus.in_ready),   64'd1);
      check_eq("rexec_busy",  64'(busy),           64'd0);
      check_eq("rexec_res",   64'(bus.out_result), 64'd0);
      step();
      step();
      step();
      check_eq("rexec_still_idle", 64'(bus.out_valid), 64'd0);

      // Reset beats a simultaneous request
      reset        = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_op    = 6'd27;
      step();
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      check_eq("rst_vs_valid_busy", 64'(busy), 64'd0);

      // MUL (op 37)
      issue(6'd37, 32'h0001_0000, 32'h0001_0000, 4'd8);
`ifdef ALU_STREAM_MUL_EN
      await_valid("mul", XLEN + 1);
      check_res("mul", 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd8);
`else
      await_valid("mul", EXEC_LAT);
      check_res("mul", 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd8);
`endif
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
